dir_input_conditioner: RTL and testbench

- Front-end stage directly upstream of the game top. It converts four raw, bouncy, asynchronous direction buttons into clean single-cycle move pulses on n, s, e, w that the game consumes.
- Each button is synchronised, then debounced with a stable-level filter.
- A press/release FSM guarantees one move per physical press and rejects ambiguous multi-button presses.
- A registered move counter is exposed for display and debug.

---
 rtl/dir_input_conditioner.sv | 117 +++++++++++
 tb/tb_dir_input_conditioner.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dir_input_conditioner.sv
// Direction-button front end: two-flop synchronisers, stable-level debounce and a
// press/release FSM that turns one clean press into one registered move pulse.
module dir_input_conditioner #(
    parameter int unsigned DB_CYCLES = 16,
    parameter int unsigned CNT_W     = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_n,
    input  logic       btn_s,
    input  logic       btn_e,
    input  logic       btn_w,
    output logic       n,
    output logic       s,
    output logic       e,
    output logic       w,
    output logic       busy,
    output logic       jam,
    output logic [7:0] moves
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HELD   = 2'd1;
    localparam logic [1:0] ST_JAMMED = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    // Bit order everywhere: [0]=n, [1]=s, [2]=e, [3]=w.
    logic [3:0]       raw;
    logic [3:0]       sync1_q;
    logic [3:0]       sync2_q;
    logic [3:0]       db_q;
    logic [CNT_W-1:0] cnt_q [4];

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [3:0]       pulse_q;
    logic [3:0]       pulse_d;
    logic [7:0]       moves_q;
    logic [7:0]       moves_d;
    logic             db_none;
    logic             db_one;

    assign raw = {btn_w, btn_e, btn_s, btn_n};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 4; i++) begin
                // db only moves after DB_CYCLES consecutive mismatching samples
                if (sync2_q[i] == db_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    db_q[i]  <= sync2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign db_none = (db_q == 4'b0000);
    assign db_one  = !db_none && ((db_q & (db_q - 4'd1)) == 4'b0000);

    always_comb begin
        state_d = state_q;
        pulse_d = 4'b0000;
        moves_d = moves_q;
        case (state_q)
            ST_IDLE: begin
                if (db_one) begin
                    pulse_d = db_q;
                    moves_d = moves_q + 8'd1;
                    state_d = ST_HELD;
                end else if (!db_none) begin
                    state_d = ST_JAMMED;
                end
            end
            ST_HELD, ST_JAMMED: begin
                if (db_none) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pulse_q <= 4'b0000;
            moves_q <= 8'd0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
            moves_q <= moves_d;
        end
    end

    assign n     = pulse_q[0];
    assign s     = pulse_q[1];
    assign e     = pulse_q[2];
    assign w     = pulse_q[3];
    assign busy  = (state_q != ST_IDLE);
    assign jam   = (state_q == ST_JAMMED);
    assign moves = moves_q;

endmodule

// File: tb/tb_dir_input_conditioner.sv
// Bench for dir_input_conditioner: directed scenarios with fixed timing expectations plus a
// cycle-by-cycle comparison against a sample-history reference model.
module tb_dir_input_conditioner;

    localparam int DB = 16;

    logic       clk;
    logic       reset;
    logic       btn_n, btn_s, btn_e, btn_w;
    logic       n, s, e, w, busy, jam;
    logic [7:0] moves;

    int vectors;
    int miscompares;
    int cnt_n, cnt_s, cnt_e, cnt_w;

    dir_input_conditioner #(
        .DB_CYCLES(DB),
        .CNT_W    (5)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .btn_n(btn_n),
        .btn_s(btn_s),
        .btn_e(btn_e),
        .btn_w(btn_w),
        .n    (n),
        .s    (s),
        .e    (e),
        .w    (w),
        .busy (busy),
        .jam  (jam),
        .moves(moves)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: db flips once the last DB synchronised samples all disagree with it.
    // mode: 0 = waiting for a press, 1 = press accepted, 2 = ambiguous press.
    typedef struct packed {
        logic [3:0]          s1;
        logic [3:0]          s2;
        logic [3:0]          db;
        logic [3:0][DB-1:0]  hist;
        logic [1:0]          mode;
        logic [3:0]          pulse;
        logic [7:0]          moves;
    } model_t;

    model_t m;

    function automatic model_t model_next(model_t c, logic [3:0] rawv);
        model_t x;
        x       = c;
        x.pulse = 4'b0000;
        if (c.mode == 2'd0) begin
            if ($countones(c.db) == 1) begin
                x.pulse = c.db;
                x.moves = c.moves + 8'd1;
                x.mode  = 2'd1;
            end else if ($countones(c.db) > 1) begin
                x.mode = 2'd2;
            end
        end else if (c.db == 4'b0000) begin
            x.mode = 2'd0;
        end
        for (int b = 0; b < 4; b++) begin
            x.hist[b] = {c.hist[b][DB-2:0], c.s2[b]};
            if (x.hist[b] == {DB{~c.db[b]}}) x.db[b] = ~c.db[b];
        end
        x.s2 = c.s1;
        x.s1 = rawv;
        return x;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) m <= '0;
        else        m <= model_next(m, {btn_w, btn_e, btn_s, btn_n});
    end

    task automatic step_cycle();
        @(negedge clk);
        vectors++;
        if ({w, e, s, n} !== m.pulse || busy !== (m.mode != 2'd0) ||
            jam !== (m.mode == 2'd2) || moves !== m.moves) begin
            miscompares++;
            $display("FAIL model t=%0t got wesn=%b busy=%b jam=%b moves=%0d want wesn=%b busy=%b jam=%b moves=%0d",
                     $time, {w, e, s, n}, busy, jam, moves, m.pulse, (m.mode != 2'd0),
                     (m.mode == 2'd2), m.moves);
        end
        vectors++;
        if ($countones({n, s, e, w}) > 1) begin
            miscompares++;
            $display("FAIL onehot t=%0t got wesn=%b want at most one bit", $time, {w, e, s, n});
        end
        cnt_n += int'(n);
        cnt_s += int'(s);
        cnt_e += int'(e);
        cnt_w += int'(w);
    endtask

    task automatic run(int cycles);
        for (int i = 0; i < cycles; i++) step_cycle();
    endtask

    task automatic clear_counts();
        cnt_n = 0; cnt_s = 0; cnt_e = 0; cnt_w = 0;
    endtask

    // Steps until busy drops; returns the number of edges taken, or -1 past the bound.
    task automatic wait_idle(output int edges);
        edges = -1;
        for (int i = 1; i <= 100; i++) begin
            step_cycle();
            if (busy === 1'b0) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        run(3);
        #2 reset = 1'b1;
        clear_counts();
    endtask

    task automatic test_reset();
        btn_n = 0; btn_s = 0; btn_e = 0; btn_w = 0;
        reset = 1'b0;
        run(3);
        vectors++;
        if ({n, s, e, w, busy, jam} !== 6'b0 || moves !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_state got nsew=%b%b%b%b busy=%b jam=%b moves=%0d want all 0",
                     n, s, e, w, busy, jam, moves);
        end
        #2 reset = 1'b1;
        clear_counts();
        run(5);
        vectors++;
        if (busy !== 1'b0 || moves !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_idle got busy=%b moves=%0d want 0 0", busy, moves);
        end
    endtask

    task automatic test_clean_north();
        int edges;
        do_reset();
        btn_n = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step_cycle();
            vectors++;
            if (n !== (k == 19)) begin
                miscompares++;
                $display("FAIL north_pulse edge=%0d got n=%b want %b", k, n, (k == 19));
            end
            if (k == 18 || k == 19) begin
                vectors++;
                if (busy !== (k == 19)) begin
                    miscompares++;
                    $display("FAIL north_busy edge=%0d got %b want %b", k, busy, (k == 19));
                end
            end
        end
        vectors++;
        if (moves !== 8'd1) begin
            miscompares++;
            $display("FAIL north_moves got %0d want 1", moves);
        end
        btn_n = 1'b0;
        wait_idle(edges);
        vectors++;
        if (edges != 19) begin
            miscompares++;
            $display("FAIL north_release got %0d edges want 19", edges);
        end
    endtask

    task automatic test_glitch();
        int edges;
        do_reset();
        btn_e = 1'b1;
        run(15);
        btn_e = 1'b0;
        run(40);
        vectors++;
        if (cnt_n + cnt_s + cnt_e + cnt_w != 0 || moves !== 8'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch got pulses=%0d moves=%0d busy=%b want 0 0 0",
                     cnt_n + cnt_s + cnt_e + cnt_w, moves, busy);
        end
        for (int t = 0; t < 4; t++) begin
            btn_e = (t % 2 == 0);
            run(3);
        end
        btn_e = 1'b1;
        run(40);
        vectors++;
        if (cnt_e != 1 || moves !== 8'd1) begin
            miscompares++;
            $display("FAIL bouncy got e_pulses=%0d moves=%0d want 1 1", cnt_e, moves);
        end
        btn_e = 1'b0;
        wait_idle(edges);
    endtask

    task automatic test_simultaneous();
        int edges;
        do_reset();
        btn_s = 1'b1;
        btn_w = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step_cycle();
            if (k == 18 || k == 19) begin
                vectors++;
                if (jam !== (k == 19)) begin
                    miscompares++;
                    $display("FAIL jam_edge edge=%0d got %b want %b", k, jam, (k == 19));
                end
            end
        end
        vectors++;
        if (cnt_s + cnt_w != 0 || moves !== 8'd0) begin
            miscompares++;
            $display("FAIL jam_pulses got %0d moves=%0d want 0 0", cnt_s + cnt_w, moves);
        end
        btn_s = 1'b0;
        btn_w = 1'b0;
        wait_idle(edges);
        vectors++;
        if (edges < 0 || jam !== 1'b0) begin
            miscompares++;
            $display("FAIL jam_release got edges=%0d jam=%b want idle and 0", edges, jam);
        end
        btn_s = 1'b1;
        run(25);
        vectors++;
        if (cnt_s != 1 || moves !== 8'd1) begin
            miscompares++;
            $display("FAIL after_jam got s_pulses=%0d moves=%0d want 1 1", cnt_s, moves);
        end
        btn_s = 1'b0;
        wait_idle(edges);
    endtask

    task automatic test_hold_add();
        int edges;
        do_reset();
        btn_n = 1'b1;
        run(25);
        btn_e = 1'b1;
        run(30);
        vectors++;
        if (cnt_e != 0 || cnt_n != 1) begin
            miscompares++;
            $display("FAIL hold_add got e=%0d n=%0d want 0 1", cnt_e, cnt_n);
        end
        btn_n = 1'b0;
        btn_e = 1'b0;
        wait_idle(edges);
        btn_e = 1'b1;
        run(25);
        vectors++;
        if (cnt_e != 1 || moves !== 8'd2) begin
            miscompares++;
            $display("FAIL hold_repress got e=%0d moves=%0d want 1 2", cnt_e, moves);
        end
        btn_e = 1'b0;
        wait_idle(edges);
    endtask

    task automatic test_reset_mid_hold();
        int edges;
        do_reset();
        btn_w = 1'b1;
        run(22);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({n, s, e, w, busy, jam} !== 6'b0 || moves !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_async got nsew=%b%b%b%b busy=%b jam=%b moves=%0d want all 0",
                     n, s, e, w, busy, jam, moves);
        end
        run(3);
        #2 reset = 1'b1;
        clear_counts();
        for (int k = 1; k <= 40; k++) begin
            step_cycle();
            vectors++;
            if (w !== (k == 19)) begin
                miscompares++;
                $display("FAIL reset_repulse edge=%0d got w=%b want %b", k, w, (k == 19));
            end
        end
        btn_w = 1'b0;
        wait_idle(edges);
    endtask

    task automatic test_random();
        int edges;
        logic [3:0] mask;
        do_reset();
        for (int b = 0; b < 60; b++) begin
            mask = 4'($urandom_range(1, 15));
            for (int c = 0; c < int'($urandom_range(5, 40)); c++) begin
                btn_n = mask[0] & ($urandom_range(0, 7) != 0);
                btn_s = mask[1] & ($urandom_range(0, 7) != 0);
                btn_e = mask[2] & ($urandom_range(0, 7) != 0);
                btn_w = mask[3] & ($urandom_range(0, 7) != 0);
                step_cycle();
            end
            btn_n = 0; btn_s = 0; btn_e = 0; btn_w = 0;
            run($urandom_range(5, 40));
        end
        wait_idle(edges);
        vectors++;
        if (edges < 0) begin
            miscompares++;
            $display("FAIL random_idle got busy=%b want 0", busy);
        end
    endtask

    task automatic test_wrap();
        int edges;
        int stuck;
        stuck = 0;
        do_reset();
        for (int p = 0; p < 256; p++) begin
            if (p % 2 == 0) btn_n = 1'b1;
            else            btn_s = 1'b1;
            run(20 + $urandom_range(0, 4));
            btn_n = 1'b0;
            btn_s = 1'b0;
            wait_idle(edges);
            if (edges < 0) stuck++;
        end
        vectors++;
        if (moves !== 8'd0 || cnt_n != 128 || cnt_s != 128 || stuck != 0) begin
            miscompares++;
            $display("FAIL wrap got moves=%0d n=%0d s=%0d stuck=%0d want 0 128 128 0",
                     moves, cnt_n, cnt_s, stuck);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clear_counts();
        test_reset();
        test_clean_north();
        test_glitch();
        test_simultaneous();
        test_hold_add();
        test_reset_mid_hold();
        test_random();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
